// File: rtl/sha1_block_seq.sv
// Feeds one 16-word block into a register-mapped SHA-1 core, polls STATUS with a bounded timeout and returns H0..H4.
// Latency: IDLE->LOAD one cycle, then one core write per accepted word; output holds under out_ready=0, input stalls on in_valid=0.
module sha1_block_seq #(
  parameter int POLL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_first,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic        core_cs,
  output logic        core_we,
  output logic [7:0]  core_address,
  output logic [31:0] core_write_data,
  input  logic [31:0] core_read_data
);

  localparam int TW = (POLL_TIMEOUT < 1) ? 1 : $clog2(POLL_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(POLL_TIMEOUT);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_BLOCK  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CTRL,
    S_SETTLE,
    S_POLL,
    S_RD,
    S_OUT
  } state_t;

  state_t        state;
  logic [3:0]    wcnt;
  logic [2:0]    dcnt;
  logic [TW-1:0] tcnt;
  logic          first_r;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);

  // Core port is combinational so a block word lands in the same cycle it is accepted.
  always_comb begin
    core_cs         = 1'b0;
    core_we         = 1'b0;
    core_address    = 8'h00;
    core_write_data = 32'h0;
    case (state)
      S_IDLE, S_POLL: begin
        core_cs      = 1'b1;
        core_address = ADDR_STATUS;
      end
      S_LOAD: begin
        if (in_valid) begin
          core_cs         = 1'b1;
          core_we         = 1'b1;
          core_address    = ADDR_BLOCK + {4'h0, wcnt};
          core_write_data = in_data;
        end
      end
      S_CTRL: begin
        core_cs         = 1'b1;
        core_we         = 1'b1;
        core_address    = ADDR_CTRL;
        core_write_data = {30'h0, ~first_r, first_r};
      end
      S_RD: begin
        core_cs      = 1'b1;
        core_address = ADDR_DIGEST + {5'h0, dcnt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= 4'h0;
      dcnt      <= 3'h0;
      tcnt      <= '0;
      first_r   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'h0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          wcnt <= 4'h0;
          if (core_read_data[0]) state <= S_LOAD;
        end
        S_LOAD: begin
          if (in_valid) begin
            if (wcnt == 4'h0) first_r <= in_first;
            if (wcnt == 4'hF) begin
              wcnt  <= 4'h0;
              state <= S_CTRL;
            end else begin
              wcnt <= wcnt + 4'h1;
            end
          end
        end
        S_CTRL: state <= S_SETTLE;
        S_SETTLE: begin
          tcnt  <= '0;
          state <= S_POLL;
        end
        S_POLL: begin
          if (core_read_data[1]) begin
            dcnt  <= 3'h0;
            state <= S_RD;
          end else begin
            if (tcnt != TMAX) tcnt <= tcnt + TW'(1);
            // Abort on the poll that brings the count up to the limit.
            if (tcnt == TMAX - TW'(1)) begin
              err   <= 1'b1;
              wcnt  <= 4'h0;
              state <= S_IDLE;
            end
          end
        end
        S_RD: begin
          out_data  <= core_read_data;
          out_valid <= 1'b1;
          out_last  <= (dcnt == 3'd4);
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (dcnt == 3'd4) begin
              dcnt  <= 3'h0;
              state <= S_IDLE;
            end else begin
              dcnt  <= dcnt + 3'h1;
              state <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_block_seq.sv
// Bench for sha1_block_seq: behavioural SHA-1 register-mapped core plus digest scoreboard.
module tb_sha1_block_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_first = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err;
  logic        core_cs;
  logic        core_we;
  logic [7:0]  core_address;
  logic [31:0] core_write_data;
  logic [31:0] core_read_data;

  always #5 clk = ~clk;

  sha1_block_seq #(.POLL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err),
    .core_cs(core_cs), .core_we(core_we), .core_address(core_address),
    .core_write_data(core_write_data), .core_read_data(core_read_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef logic [15:0][31:0] blk_t;
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  function automatic logic [159:0] sha1_compress(input logic [159:0] hin, input blk_t blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Behavioural core: block/ctrl writes, 3-cycle compute, STATUS/DIGEST reads.
  blk_t         core_blk = '0;
  logic [159:0] core_h = '0;
  logic         core_valid = 1'b0;
  int           core_busy = 0;
  logic         core_rdy_en = 1'b0;
  logic         never_valid = 1'b0;

  always @(posedge clk) begin
    if (core_cs && core_we) begin
      if (core_address >= 8'h10 && core_address <= 8'h1F)
        core_blk[core_address[3:0]] <= core_write_data;
      else if (core_address == 8'h08) begin
        if (core_write_data[0])      core_h <= sha1_compress(IV, core_blk);
        else if (core_write_data[1]) core_h <= sha1_compress(core_h, core_blk);
        core_valid <= 1'b0;
        core_busy  <= 3;
      end
    end else if (core_busy > 0) begin
      core_busy <= core_busy - 1;
      if (core_busy == 1 && !never_valid) core_valid <= 1'b1;
    end
  end

  always_comb begin
    core_read_data = 32'h0;
    if (core_cs && !core_we) begin
      if (core_address == 8'h09)
        core_read_data = {30'h0, core_valid, core_rdy_en && (core_busy == 0)};
      else if (core_address >= 8'h20 && core_address <= 8'h24)
        core_read_data = core_h[int'(8'h24 - core_address) * 32 +: 32];
    end
  end

  // Scoreboard, write log and output stability monitor.
  typedef struct packed { logic [31:0] d; logic l; } exp_t;
  exp_t        sb [$];
  exp_t        e_pop;
  exp_t        e_push;
  logic [39:0] wr_log [$];
  logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_dat = 32'h0;

  always @(negedge clk) begin
    if (core_cs && core_we) wr_log.push_back({core_address, core_write_data});
    if (out_valid && prev_vld && !prev_rdy) begin
      chk("stall_data_stable", out_data, prev_dat);
      chk("stall_last_stable", out_last, prev_last);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_digest_word actual=%0h required=none", out_data);
      end else begin
        e_pop = sb.pop_front();
        chk("digest_word", out_data, e_pop.d);
        chk("digest_last", out_last, e_pop.l);
      end
    end
    prev_vld  = out_valid;
    prev_rdy  = out_ready;
    prev_dat  = out_data;
    prev_last = out_last;
  end

  // Consumer: always ready, or hold out_ready low ~10 cycles per word.
  logic stall_en = 1'b0;
  int   stall_cnt = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!stall_en) out_ready = 1'b1;
    else if (out_valid && !out_ready) begin
      if (stall_cnt >= 9) out_ready = 1'b1;
      else stall_cnt++;
    end else begin
      out_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_block(input blk_t blk, input logic first, input int gap, input int nw);
    int idx = 0;
    int guard = 0;
    logic hs;
    while (idx < nw && guard < 3000) begin
      in_valid = (gap == 0) || ($urandom_range(99) >= gap);
      in_data  = blk[idx];
      in_first = first;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_first = 1'b0;
    chk("send_words_accepted", idx, nw);
  endtask

  task automatic push_digest(input logic [159:0] dig);
    for (int j = 0; j < 5; j++) begin
      e_push.d = dig[159 - 32*j -: 32];
      e_push.l = (j == 4);
      sb.push_back(e_push);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("digest_drained", sb.size(), 0);
  endtask

  typedef struct {
    blk_t         blk;
    logic         first;
    logic [159:0] dig;
    logic [31:0]  ctrl;
    int           gap;
    logic         stall;
  } vec_t;

  vec_t         vec [4];
  blk_t         abc_blk, nist1, nist2;
  logic         ok, seen, ovs;
  int           poll, nctrl;
  localparam logic [159:0] ABC_DIG  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] NIST_DIG = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  initial begin
    abc_blk = '0;
    abc_blk[0] = 32'h61626380; abc_blk[15] = 32'h00000018;
    nist1[0]  = 32'h61626364; nist1[1]  = 32'h62636465; nist1[2]  = 32'h63646566; nist1[3]  = 32'h64656667;
    nist1[4]  = 32'h65666768; nist1[5]  = 32'h66676869; nist1[6]  = 32'h6768696a; nist1[7]  = 32'h68696a6b;
    nist1[8]  = 32'h696a6b6c; nist1[9]  = 32'h6a6b6c6d; nist1[10] = 32'h6b6c6d6e; nist1[11] = 32'h6c6d6e6f;
    nist1[12] = 32'h6d6e6f70; nist1[13] = 32'h6e6f7071; nist1[14] = 32'h80000000; nist1[15] = 32'h00000000;
    nist2 = '0;
    nist2[15] = 32'h000001c0;
    vec[0] = '{abc_blk, 1'b1, ABC_DIG,                    32'h1, 0,  1'b0};
    vec[1] = '{nist1,   1'b1, sha1_compress(IV, nist1),   32'h1, 0,  1'b0};
    vec[2] = '{nist2,   1'b0, NIST_DIG,                   32'h2, 0,  1'b0};
    vec[3] = '{abc_blk, 1'b1, ABC_DIG,                    32'h1, 40, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_cs", core_cs, 1);
    chk("rst_core_we", core_we, 0);
    chk("rst_core_addr", core_address, 8'h09);
    chk("rst_core_wdata", core_write_data, 0);

    // Core not ready: sequencer waits in IDLE.
    repeat (4) begin
      @(negedge clk);
      chk("notready_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    core_rdy_en = 1'b1;
    @(negedge clk);
    chk("ready_same_cycle_in_ready", in_ready, 0);
    @(negedge clk);
    chk("ready_next_cycle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      stall_en = vec[v].stall;
      wr_log.delete();
      push_digest(vec[v].dig);
      send_block(vec[v].blk, vec[v].first, vec[v].gap, 16);
      wait_drain();
      chk("core_write_count", wr_log.size(), 17);
      if (wr_log.size() >= 17) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
          if (wr_log[i] !== {8'h10 + 8'(i), vec[v].blk[i]}) ok = 1'b0;
        chk("block_write_order", ok, 1);
        chk("ctrl_write", wr_log[16], {8'h08, vec[v].ctrl});
      end
    end
    stall_en = 1'b0;

    // Poll timeout: core never reports a digest.
    never_valid = 1'b1;
    send_block(abc_blk, 1'b1, 0, 16);
    poll = 0; seen = 1'b0; ovs = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) ovs = 1'b1;
      if (err) begin
        seen = 1'b1;
        chk("timeout_busy_at_err", busy, 0);
      end else if (busy && core_cs && !core_we && core_address == 8'h09) poll++;
    end
    chk("timeout_err_seen", seen, 1);
    chk("timeout_poll_cycles", poll, 8);
    @(negedge clk);
    chk("timeout_err_width", err, 0);
    chk("timeout_no_output", ovs | out_valid, 0);
    never_valid = 1'b0;
    @(posedge clk); #1;

    // Reset after word 7 of a block.
    wr_log.delete();
    send_block(nist1, 1'b1, 0, 8);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_in_ready", in_ready, 0);
    chk("midload_rst_out_valid", out_valid, 0);
    chk("midload_rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midload_idle_cs", core_cs, 1);
    chk("midload_idle_addr", core_address, 8'h09);
    nctrl = 0;
    foreach (wr_log[i]) if (wr_log[i][39:32] == 8'h08) nctrl++;
    chk("midload_no_ctrl", nctrl, 0);
    chk("midload_write_count", wr_log.size(), 8);
    @(posedge clk); #1;
    push_digest(ABC_DIG);
    send_block(abc_blk, 1'b1, 0, 16);
    wait_drain();

    // Reset while a digest word is stalled in OUT.
    stall_en = 1'b1;
    send_block(abc_blk, 1'b1, 0, 16);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midout_reached", seen, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midout_valid_fall", out_valid, 0);
    chk("midout_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    stall_en = 1'b0;
    push_digest(ABC_DIG);
    send_block(abc_blk, 1'b1, 0, 16);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha1_block_seq.md
SHA1_BLOCK_SEQ -- requirements
Module: sha1_block_seq

Interface
REQ-001 Parameter POLL_TIMEOUT, default 1023: maximum number of STATUS poll cycles after a CTRL write before the block aborts.
REQ-002 clk  input  1  clock; all logic is rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  an input message word is offered.
REQ-005 in_ready  output  1  sequencer accepts a word this cycle.
REQ-006 in_data  input  32  message word, big-endian word order W0..W15.
REQ-007 in_first  input  1  sampled with W0: 1 = first block of a message (INIT), 0 = continuation (NEXT).
REQ-008 out_valid  output  1  digest word available.
REQ-009 out_ready  input  1  consumer accepts the digest word.
REQ-010 out_data  output  32  digest word H0..H4.
REQ-011 out_last  output  1  high with H4.
REQ-012 busy  output  1  low only in IDLE.
REQ-013 err  output  1  one-cycle pulse on poll timeout.
REQ-014 core_cs, core_we  output  1 each  sha1 core register-port select and write enable.
REQ-015 core_address  output  8  core register address.
REQ-016 core_write_data  output  32  core write data.
REQ-017 core_read_data  input  32  core read data, combinational and valid in the same cycle as core_cs=1 and core_we=0.

Function
REQ-018 The block SHALL use core map STATUS=0x09 (bit0 ready, bit1 valid), CTRL=0x08 (bit0 init, bit1 next), BLOCK0..15=0x10..0x1F, DIGEST0..4=0x20..0x24.
REQ-019 IDLE: drive cs=1, we=0, addr=STATUS, in_ready=0; when core_read_data[0]=1, go to LOAD next cycle.
REQ-020 LOAD: in_ready=1.
- On each in_valid&in_ready cycle, same cycle: cs=1, we=1, addr=0x10+wcnt, write_data=in_data; then wcnt increments.
- Otherwise cs=0.
- in_first is registered on the word with wcnt=0.
- The word with wcnt=15 moves the FSM to CTRL.
REQ-021 CTRL: one cycle, cs=1, we=1, addr=CTRL, write_data = {30'b0, ~first_r, first_r}; go to SETTLE.
REQ-022 SETTLE: one cycle with cs=0, then POLL with the timeout counter cleared.
REQ-023 POLL: cs=1, we=0, addr=STATUS each cycle.
- If core_read_data[1]=1: go to RD with dcnt=0.
- Otherwise the timeout counter increments.
- When the counter reaches POLL_TIMEOUT: err=1 for one cycle, return to IDLE, wcnt cleared, no digest output.
REQ-024 RD: one cycle, cs=1, we=0, addr=0x20+dcnt; out_data is registered from core_read_data, out_valid is set, out_last is set iff dcnt=4; go to OUT.
REQ-025 OUT: cs=0; out_data, out_valid and out_last are held stable until out_ready.
- On out_valid&out_ready: out_valid and out_last clear.
- If dcnt=4, go to IDLE; otherwise dcnt increments and the FSM goes to RD.
REQ-026 Input-to-output throughput SHALL be one digest word per two cycles at best; words are never dropped or duplicated.
REQ-027 Outside write cycles, core_write_data SHALL be 0.
REQ-028 in_ready SHALL be 0 in every state except LOAD; back-pressure in LOAD (in_valid=0) SHALL stall without a core write.
REQ-029 Counters: wcnt is 4 bits and dcnt is 3 bits; neither SHALL wrap within a block.
REQ-030 The timeout counter SHALL be sized ceil(log2(POLL_TIMEOUT+1)) bits and SHALL saturate at POLL_TIMEOUT.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 On rst, the following SHALL be 0: state=IDLE, wcnt, dcnt, timeout counter, first_r, out_valid, out_last, out_data, err.
REQ-033 Combinational core outputs SHALL follow the IDLE values on the cycle after rst deasserts.
REQ-034 rst asserted mid-LOAD, mid-POLL or mid-OUT SHALL abandon the block; out_valid falls in the cycle after the rst edge and the partial block is not resumed.

Verification
REQ-035 Single block "abc": padded 16 words with in_first=1 against a sha1 core model -> exactly one CTRL write of 0x1, then digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d with out_last on the 5th word only.
REQ-036 Two-block message: 448-bit NIST vector, block 1 with in_first=1 and block 2 with in_first=0 -> CTRL writes 0x1 then 0x2; final digest 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
REQ-037 Back-pressure: random in_valid gaps and out_ready held low 10 cycles per word -> addresses 0x10..0x1F each written exactly once in order; out_data stable while stalled.
REQ-038 Timeout: core model never sets the valid bit, POLL_TIMEOUT=8 -> err pulses 1 cycle exactly 8 POLL cycles after SETTLE, FSM in IDLE, out_valid stays 0.
REQ-039 Reset during LOAD after word 7 -> all outputs at reset values; no CTRL write observed; a following full block hashes correctly.
REQ-040 Core not ready (STATUS bit0=0) -> in_ready stays 0 until bit0=1, then rises on the next cycle.
